// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and FSM encoding for the burst master
package mem_pkg;

  localparam int MEM_WIDTH      = 8;
  localparam int MEM_DEPTH      = 32;
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// rtl/mem_addr_gen.sv - beat index counter, wrapping address and seed+index pattern
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] start,
  input  logic [WIDTH-1:0]      seed,
  output logic [ADDR_WIDTH:0]   index,
  output logic [WIDTH-1:0]      pat_cur,
  output logic [ADDR_WIDTH-1:0] addr_nxt,
  output logic [WIDTH-1:0]      pat_nxt
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0]      seed_q, seed_d;

  // start + offset modulo DEPTH; both operands are below DEPTH (offset <= DEPTH),
  // so a single conditional subtract is enough even for non power-of-two depths
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ADDR_WIDTH:0]   off);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // next index/start/seed: a load restarts the burst, an accepted beat steps the index
  always_comb begin
    index_d = index_q;
    start_d = start_q;
    seed_d  = seed_q;
    if (load) begin
      index_d = '0;
      start_d = start;
      seed_d  = seed;
    end else if (advance) begin
      index_d = index_q + IDX_ONE;
    end
  end

  // counter and burst parameter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      start_q <= '0;
      seed_q  <= '0;
    end else begin
      index_q <= index_d;
      start_q <= start_d;
      seed_q  <= seed_d;
    end
  end

  // current pattern feeds the read compare; next values feed the registered outputs
  always_comb begin
    index    = index_q;
    pat_cur  = seed_q + WIDTH'(index_q);
    addr_nxt = wrap_addr(start_d, index_d);
    pat_nxt  = seed_d + WIDTH'(index_d);
  end

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst read/write master with read-compare error counter
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_start,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [WIDTH-1:0]      cmd_seed,
  output logic                  valid,
  input  logic                  ready,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_cnt
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;

  logic                  load;
  logic                  advance;
  logic [ADDR_WIDTH:0]   index;
  logic [WIDTH-1:0]      pat_cur;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [WIDTH-1:0]      pat_nxt;

  mem_addr_gen #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (res),
    .load     (load),
    .advance  (advance),
    .start    (cmd_start),
    .seed     (cmd_seed),
    .index    (index),
    .pat_cur  (pat_cur),
    .addr_nxt (addr_nxt),
    .pat_nxt  (pat_nxt)
  );

  // next state, next registered outputs, read compare and error counting
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    valid_d    = valid_q;
    wr_rd_d    = wr_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_cnt_d  = err_cnt_q;
    load       = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          len_d     = cmd_len;
          err_cnt_d = '0;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_XFER;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            wr_rd_d = cmd_wr_rd;
            addr_d  = addr_nxt;
            wdata_d = cmd_wr_rd ? pat_nxt : '0;
          end
        end
      end

      ST_XFER: begin
        if (valid_q && ready) begin
          advance = 1'b1;
          if (!wr_rd_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rdata;
            if (rdata != pat_cur && err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
          end
          if (index == len_q - CNT_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            wr_rd_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            addr_d  = addr_nxt;
            wdata_d = wr_rd_q ? pat_nxt : '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers; reset abandons any burst without waiting for a clock
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      valid_q    <= 1'b0;
      wr_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      valid_q    <= valid_d;
      wr_rd_q    <= wr_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // output drive straight from registers; cmd_ready decoded from state
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    valid     = valid_q;
    wr_rd     = wr_rd_q;
    addr      = addr_q;
    wdata     = wdata_q;
    busy      = busy_q;
    done      = done_q;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
    err_cnt   = err_cnt_q;
  end

endmodule
